// File: rtl/bldc_dead_time_inserter_if.sv
// Control/status bundle between the PWM source (master) and the
// dead-time inserter (slave).
interface bldc_dead_time_inserter_if #(
  parameter int dead_ticks_width = 8
);
  logic                        enable;
  logic [dead_ticks_width-1:0] dead_ticks;
  logic [5:0]                  pwm_in;
  logic                        fault_clear;
  logic [5:0]                  gate_out;
  logic [2:0]                  fault;
  logic                        busy;

  modport master (
    output enable, dead_ticks, pwm_in, fault_clear,
    input  gate_out, fault, busy
  );

  modport slave (
    input  enable, dead_ticks, pwm_in, fault_clear,
    output gate_out, fault, busy
  );
endinterface

// File: rtl/bldc_dead_time_inserter.sv
// Gate-drive conditioning: per-phase dead-time insertion on every turn-on
// and shoot-through blocking with a sticky per-phase fault flag.
// Phase p (0=C, 1=B, 2=A) uses high request pwm_in[3+p], low request pwm_in[p].
module bldc_dead_time_inserter #(
  parameter int dead_ticks_width = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  bldc_dead_time_inserter_if.slave        bus
);

  typedef enum logic [2:0] {
    S_OFF,
    S_DEAD_H,
    S_DEAD_L,
    S_ON_H,
    S_ON_L
  } state_e;

  localparam logic [dead_ticks_width-1:0] CNT_ONE = 1;

  state_e                      state_q [3];
  state_e                      state_d [3];
  logic [dead_ticks_width-1:0] cnt_q   [3];
  logic [dead_ticks_width-1:0] cnt_d   [3];
  logic [5:0]                  gate_q, gate_d;
  logic [2:0]                  fault_q, fault_d, fault_set;
  logic                        busy_q, busy_d;

  logic [2:0] h_only, l_only, both_req;
  logic       dead_zero;

  assign h_only    =  bus.pwm_in[5:3] & ~bus.pwm_in[2:0];
  assign l_only    = ~bus.pwm_in[5:3] &  bus.pwm_in[2:0];
  assign both_req  =  bus.pwm_in[5:3] &  bus.pwm_in[2:0];
  assign dead_zero = (bus.dead_ticks == '0);

  // Next-state decode for the three phase FSMs; gates and busy decoded from next state
  always_comb begin
    gate_d    = '0;
    busy_d    = 1'b0;
    fault_set = '0;
    for (int p = 0; p < 3; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      if (!bus.enable) begin
        state_d[p] = S_OFF;
        cnt_d[p]   = '0;
      end else if (fault_q[p] && !bus.fault_clear) begin
        // latched fault parks the phase; a clear pulse releases it on the same edge
        state_d[p] = S_OFF;
        cnt_d[p]   = '0;
      end else if (state_q[p] == S_DEAD_H && h_only[p]) begin
        if (cnt_q[p] > CNT_ONE) begin
          cnt_d[p] = cnt_q[p] - CNT_ONE;
        end else begin
          state_d[p] = S_ON_H;
          cnt_d[p]   = '0;
        end
      end else if (state_q[p] == S_DEAD_L && l_only[p]) begin
        if (cnt_q[p] > CNT_ONE) begin
          cnt_d[p] = cnt_q[p] - CNT_ONE;
        end else begin
          state_d[p] = S_ON_L;
          cnt_d[p]   = '0;
        end
      end else if ((state_q[p] == S_ON_H && h_only[p]) ||
                   (state_q[p] == S_ON_L && l_only[p])) begin
        state_d[p] = state_q[p];
      end else if (h_only[p]) begin
        // fresh entry (also a side swap mid-dead): reload the full dead time
        state_d[p] = dead_zero ? S_ON_H : S_DEAD_H;
        cnt_d[p]   = dead_zero ? '0 : bus.dead_ticks;
      end else if (l_only[p]) begin
        state_d[p] = dead_zero ? S_ON_L : S_DEAD_L;
        cnt_d[p]   = dead_zero ? '0 : bus.dead_ticks;
      end else begin
        state_d[p]   = S_OFF;
        cnt_d[p]     = '0;
        fault_set[p] = both_req[p];
      end

      gate_d[3+p] = (state_d[p] == S_ON_H);
      gate_d[p]   = (state_d[p] == S_ON_L);
      busy_d      = busy_d | (state_d[p] == S_DEAD_H) | (state_d[p] == S_DEAD_L);
    end
    // a new shoot-through in the same cycle as a clear keeps the flag set
    fault_d = (fault_q & ~{3{bus.fault_clear}}) | fault_set;
  end

  // State, counters and registered outputs; reset drops every gate immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '{default: S_OFF};
      cnt_q   <= '{default: '0};
      gate_q  <= '0;
      fault_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gate_out = gate_q;
  assign bus.fault    = fault_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_bldc_dead_time_inserter.sv
// Scoreboard bench for the dead-time inserter: directed scenarios push
// expected {gate_out, fault, busy} per edge, then drain and compare.
module tb_bldc_dead_time_inserter;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bldc_dead_time_inserter_if #(.dead_ticks_width(W)) bus();

  bldc_dead_time_inserter #(.dead_ticks_width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [5:0] gate;
    logic [2:0] fault;
    logic       busy;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [5:0] g, input logic [2:0] f, input logic b);
    exp_t e;
    e.gate  = g;
    e.fault = f;
    e.busy  = b;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.dead_ticks  = 8'd4;
    bus.pwm_in      = 6'b0;
    bus.fault_clear = 1'b0;
    sbq.push_back(mk(6'b0, 3'b0, 1'b0));
    repeat (3) tick();
    e = sbq.pop_front();
    checks++;
    if ({bus.gate_out, bus.fault, bus.busy} !== e) begin
      failures++;
      $display("FAIL reset got gate=%b fault=%b busy=%b exp gate=%b fault=%b busy=%b",
               bus.gate_out, bus.fault, bus.busy, e.gate, e.fault, e.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_turn_on();
    exp_t e;
    int   cyc = 0;
    bus.enable = 1'b1;
    bus.pwm_in = 6'b0;
    tick();
    bus.pwm_in = 6'b100000;
    repeat (4) sbq.push_back(mk(6'b0, 3'b0, 1'b1));
    repeat (2) sbq.push_back(mk(6'b100000, 3'b0, 1'b0));
    while (sbq.size() > 0) begin
      tick();
      e = sbq.pop_front();
      checks++;
      if ({bus.gate_out, bus.fault, bus.busy} !== e) begin
        failures++;
        $display("FAIL turn_on cyc%0d got gate=%b fault=%b busy=%b exp gate=%b fault=%b busy=%b",
                 cyc, bus.gate_out, bus.fault, bus.busy, e.gate, e.fault, e.busy);
      end
      cyc++;
    end
  endtask

  task automatic test_commutate();
    exp_t e;
    int   cyc = 0;
    bus.pwm_in = 6'b000100;
    repeat (4) sbq.push_back(mk(6'b0, 3'b0, 1'b1));
    repeat (2) sbq.push_back(mk(6'b000100, 3'b0, 1'b0));
    while (sbq.size() > 0) begin
      tick();
      e = sbq.pop_front();
      checks++;
      if ({bus.gate_out, bus.fault, bus.busy} !== e) begin
        failures++;
        $display("FAIL commutate cyc%0d got gate=%b fault=%b busy=%b exp gate=%b fault=%b busy=%b",
                 cyc, bus.gate_out, bus.fault, bus.busy, e.gate, e.fault, e.busy);
      end
      cyc++;
    end
  endtask

  task automatic test_fault();
    exp_t e;
    int   cyc = 0;
    // bring B high and C low on while A stays low-side on
    bus.pwm_in = 6'b010101;
    repeat (4) sbq.push_back(mk(6'b000100, 3'b000, 1'b1));
    sbq.push_back(mk(6'b010101, 3'b000, 1'b0));
    // one cycle of shoot-through request on A
    sbq.push_back(mk(6'b010001, 3'b100, 1'b0));
    // A high-only but held by the fault
    repeat (6) sbq.push_back(mk(6'b010001, 3'b100, 1'b0));
    // clear edge: A restarts with a full dead time
    repeat (4) sbq.push_back(mk(6'b010001, 3'b000, 1'b1));
    sbq.push_back(mk(6'b110001, 3'b000, 1'b0));
    // set and clear together: set wins
    sbq.push_back(mk(6'b010001, 3'b100, 1'b0));
    // plain clear
    sbq.push_back(mk(6'b010001, 3'b000, 1'b0));
    while (sbq.size() > 0) begin
      case (cyc)
        5:       begin bus.pwm_in = 6'b110101; bus.fault_clear = 1'b0; end
        6:       begin bus.pwm_in = 6'b110001; bus.fault_clear = 1'b0; end
        12:      begin bus.pwm_in = 6'b110001; bus.fault_clear = 1'b1; end
        17:      begin bus.pwm_in = 6'b110101; bus.fault_clear = 1'b1; end
        18:      begin bus.pwm_in = 6'b010001; bus.fault_clear = 1'b1; end
        default: bus.fault_clear = 1'b0;
      endcase
      tick();
      e = sbq.pop_front();
      checks++;
      if ({bus.gate_out, bus.fault, bus.busy} !== e) begin
        failures++;
        $display("FAIL fault cyc%0d got gate=%b fault=%b busy=%b exp gate=%b fault=%b busy=%b",
                 cyc, bus.gate_out, bus.fault, bus.busy, e.gate, e.fault, e.busy);
      end
      cyc++;
    end
    bus.fault_clear = 1'b0;
  endtask

  task automatic test_zero_dead();
    exp_t e;
    logic [5:0] req;
    bus.dead_ticks = 8'd0;
    bus.pwm_in     = 6'b0;
    sbq.push_back(mk(6'b0, 3'b0, 1'b0));
    tick();
    e = sbq.pop_front();
    checks++;
    if ({bus.gate_out, bus.fault, bus.busy} !== e) begin
      failures++;
      $display("FAIL zero_dead_idle got gate=%b fault=%b busy=%b exp gate=%b fault=%b busy=%b",
               bus.gate_out, bus.fault, bus.busy, e.gate, e.fault, e.busy);
    end
    for (int i = 0; i < 10; i++) begin
      req        = (i % 2 == 0) ? 6'b001000 : 6'b000001;
      bus.pwm_in = req;
      sbq.push_back(mk(req, 3'b0, 1'b0));
      tick();
      e = sbq.pop_front();
      checks++;
      if ({bus.gate_out, bus.fault, bus.busy} !== e) begin
        failures++;
        $display("FAIL zero_dead cyc%0d got gate=%b fault=%b busy=%b exp gate=%b fault=%b busy=%b",
                 i, bus.gate_out, bus.fault, bus.busy, e.gate, e.fault, e.busy);
      end
    end
  endtask

  task automatic test_dead_change();
    exp_t e;
    int   cyc = 0;
    bus.dead_ticks = 8'd4;
    bus.pwm_in     = 6'b0;
    sbq.push_back(mk(6'b0, 3'b0, 1'b0));
    repeat (4) sbq.push_back(mk(6'b0, 3'b0, 1'b1));
    sbq.push_back(mk(6'b100000, 3'b0, 1'b0));
    // minimum non-zero dead time: one cycle of both-low
    sbq.push_back(mk(6'b0, 3'b0, 1'b1));
    sbq.push_back(mk(6'b000100, 3'b0, 1'b0));
    while (sbq.size() > 0) begin
      case (cyc)
        1: bus.pwm_in = 6'b100000;
        4: bus.dead_ticks = 8'd20;
        6: begin bus.dead_ticks = 8'd1; bus.pwm_in = 6'b000100; end
        default: ;
      endcase
      tick();
      e = sbq.pop_front();
      checks++;
      if ({bus.gate_out, bus.fault, bus.busy} !== e) begin
        failures++;
        $display("FAIL dead_change cyc%0d got gate=%b fault=%b busy=%b exp gate=%b fault=%b busy=%b",
                 cyc, bus.gate_out, bus.fault, bus.busy, e.gate, e.fault, e.busy);
      end
      cyc++;
    end
  endtask

  task automatic test_enable();
    exp_t e;
    int   cyc = 0;
    bus.dead_ticks = 8'd4;
    repeat (2) sbq.push_back(mk(6'b0, 3'b0, 1'b0));
    sbq.push_back(mk(6'b0, 3'b0, 1'b0));
    repeat (4) sbq.push_back(mk(6'b0, 3'b0, 1'b1));
    sbq.push_back(mk(6'b100000, 3'b0, 1'b0));
    while (sbq.size() > 0) begin
      case (cyc)
        0: begin bus.enable = 1'b0; bus.pwm_in = 6'b000100; end
        2: bus.pwm_in = 6'b100100;
        3: begin bus.enable = 1'b1; bus.pwm_in = 6'b100000; end
        default: ;
      endcase
      tick();
      e = sbq.pop_front();
      checks++;
      if ({bus.gate_out, bus.fault, bus.busy} !== e) begin
        failures++;
        $display("FAIL enable cyc%0d got gate=%b fault=%b busy=%b exp gate=%b fault=%b busy=%b",
                 cyc, bus.gate_out, bus.fault, bus.busy, e.gate, e.fault, e.busy);
      end
      cyc++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   cyc = 0;
    bus.pwm_in = 6'b010001;
    repeat (4) sbq.push_back(mk(6'b0, 3'b0, 1'b1));
    sbq.push_back(mk(6'b010001, 3'b0, 1'b0));
    while (sbq.size() > 0) begin
      tick();
      e = sbq.pop_front();
      checks++;
      if ({bus.gate_out, bus.fault, bus.busy} !== e) begin
        failures++;
        $display("FAIL async_setup cyc%0d got gate=%b fault=%b busy=%b exp gate=%b fault=%b busy=%b",
                 cyc, bus.gate_out, bus.fault, bus.busy, e.gate, e.fault, e.busy);
      end
      cyc++;
    end
    // mid-cycle reset, well away from any clock edge
    #2;
    sbq.push_back(mk(6'b0, 3'b0, 1'b0));
    reset = 1'b1;
    #1;
    e = sbq.pop_front();
    checks++;
    if ({bus.gate_out, bus.fault, bus.busy} !== e) begin
      failures++;
      $display("FAIL async_reset got gate=%b fault=%b busy=%b exp gate=%b fault=%b busy=%b",
               bus.gate_out, bus.fault, bus.busy, e.gate, e.fault, e.busy);
    end
    bus.pwm_in = 6'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [1:0] req [3];
    logic [5:0] prev_gate;
    int         lowrun [3];
    int         d;
    logic       hi, lo;
    d         = 3;
    prev_gate = bus.gate_out;
    for (int p = 0; p < 3; p++) begin
      req[p]    = 2'b00;
      lowrun[p] = 1000;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc % 2000 == 0) begin
        // change dead time only while everything is parked in OFF
        bus.enable = 1'b0;
        tick();
        tick();
        d              = $urandom_range(0, 6);
        bus.dead_ticks = d[W-1:0];
        prev_gate      = bus.gate_out;
        for (int p = 0; p < 3; p++) lowrun[p] = 1000;
      end
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 31) == 0) req[p] = 2'b11;
          else req[p] = 2'($urandom_range(0, 2));
        end
        bus.pwm_in[3+p] = req[p][1];
        bus.pwm_in[p]   = req[p][0];
      end
      bus.enable      = ($urandom_range(0, 63) != 0);
      bus.fault_clear = ($urandom_range(0, 15) == 0);
      tick();
      for (int p = 0; p < 3; p++) begin
        hi = bus.gate_out[3+p];
        lo = bus.gate_out[p];
        checks++;
        if (hi && lo) begin
          failures++;
          $display("FAIL overlap cyc%0d phase%0d got gate=%b exp no overlap", cyc, p, bus.gate_out);
        end
        if ((hi && !prev_gate[3+p]) || (lo && !prev_gate[p])) begin
          checks++;
          if (lowrun[p] < d) begin
            failures++;
            $display("FAIL dead_gap cyc%0d phase%0d got low_cycles=%0d exp >=%0d", cyc, p, lowrun[p], d);
          end
        end
        if (!hi && !lo) begin
          if (lowrun[p] < 1000) lowrun[p]++;
        end else begin
          lowrun[p] = 0;
        end
      end
      prev_gate = bus.gate_out;
    end
    bus.fault_clear = 1'b0;
    bus.pwm_in      = 6'b0;
  endtask

  initial begin
    test_reset();
    test_turn_on();
    test_commutate();
    test_fault();
    test_zero_dead();
    test_dead_change();
    test_enable();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
